// File: rtl/fan_tach_monitor.sv
// Multi-channel fan tachometer monitor: per-channel windowed edge counting, speed flags and a
// hysteretic fault FSM. Optional stall timer enabled by defining FAN_TACH_STALL_EN.
module fan_tach_monitor #(
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned CNT_W    = 12,
  parameter int unsigned WIN_LOG2 = 15,
  parameter int unsigned MIN_TACH = 'h014,
  parameter int unsigned MAX_TACH = 'h0E0,
  parameter int unsigned FLT_CNT  = 3
) (
  input  logic                    CLKi,
  input  logic                    ResetNi,
  input  logic [NUM_CH-1:0]       Fan_In,
  input  logic [NUM_CH-1:0]       ChEnable,
  output logic [NUM_CH*CNT_W-1:0] FanCnt,
  output logic [NUM_CH-1:0]       TachLow,
  output logic [NUM_CH-1:0]       TachHigh,
  output logic [NUM_CH-1:0]       FanFault,
  output logic                    WinDone
);

  localparam logic [CNT_W-1:0] MinTach = CNT_W'(MIN_TACH);
  localparam logic [CNT_W-1:0] MaxTach = CNT_W'(MAX_TACH);
  localparam logic [3:0]       FltCnt  = 4'(FLT_CNT);

  typedef enum logic [1:0] {StOk, StSuspect, StFault} state_e;

  logic [NUM_CH-1:0]       sync1_q, sync2_q, sync3_q;
  logic [NUM_CH-1:0]       edge_det;
  logic [WIN_LOG2-1:0]     win_q, win_d;
  logic                    tc;
  logic [CNT_W:0]          edgecnt_q [NUM_CH];
  logic [CNT_W:0]          edgecnt_d [NUM_CH];
  logic [NUM_CH*CNT_W-1:0] fan_cnt_q, fan_cnt_d;
  logic [NUM_CH-1:0]       low_q, low_d, high_q, high_d, fault_q, fault_d;
  state_e                  state_q [NUM_CH];
  state_e                  state_d [NUM_CH];
  logic [3:0]              run_q [NUM_CH];
  logic [3:0]              run_d [NUM_CH];
  logic                    win_done_q;
`ifdef FAN_TACH_STALL_EN
  logic [WIN_LOG2-3:0]     stall_q [NUM_CH];
  logic [WIN_LOG2-3:0]     stall_d [NUM_CH];
`endif

  assign edge_det = sync2_q ^ sync3_q;
  assign tc       = &win_q;
  assign win_d    = win_q + 1'b1;

  always_comb begin
    logic [CNT_W-1:0] cnt_new;
    logic [3:0]       run_inc;
    logic             bad;
    cnt_new   = '0;
    run_inc   = '0;
    bad       = 1'b0;
    fan_cnt_d = fan_cnt_q;
    low_d     = low_q;
    high_d    = high_q;
    fault_d   = fault_q;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cnt_new      = edgecnt_q[i][CNT_W:1];
      run_inc      = run_q[i] + 4'd1;
      edgecnt_d[i] = edgecnt_q[i];
      state_d[i]   = state_q[i];
      run_d[i]     = run_q[i];
      if (edge_det[i] && !(&edgecnt_q[i])) begin
        edgecnt_d[i] = edgecnt_q[i] + 1'b1;
      end
      if (tc) begin
        // An edge seen in the terminal-count cycle opens the next window.
        edgecnt_d[i] = {{CNT_W{1'b0}}, edge_det[i]};
        fan_cnt_d[i*CNT_W +: CNT_W] = cnt_new;
        low_d[i]  = (cnt_new <= MinTach);
        high_d[i] = (cnt_new > MaxTach);
        bad       = low_d[i] | high_d[i];
        unique case (state_q[i])
          StOk: begin
            if (bad) begin
              if (FltCnt == 4'd1) begin
                state_d[i] = StFault;
                run_d[i]   = '0;
              end else begin
                state_d[i] = StSuspect;
                run_d[i]   = 4'd1;
              end
            end
          end
          StSuspect: begin
            if (!bad) begin
              state_d[i] = StOk;
              run_d[i]   = '0;
            end else if (run_inc == FltCnt) begin
              state_d[i] = StFault;
              run_d[i]   = '0;
            end else begin
              run_d[i] = run_inc;
            end
          end
          StFault: begin
            if (bad) begin
              run_d[i] = '0;
            end else if (run_inc == FltCnt) begin
              state_d[i] = StOk;
              run_d[i]   = '0;
            end else begin
              run_d[i] = run_inc;
            end
          end
          default: begin
            state_d[i] = StOk;
            run_d[i]   = '0;
          end
        endcase
      end
`ifdef FAN_TACH_STALL_EN
      if (edge_det[i]) begin
        stall_d[i] = '0;
      end else if (&stall_q[i]) begin
        stall_d[i] = stall_q[i];
      end else begin
        stall_d[i] = stall_q[i] + 1'b1;
      end
      // A stopped fan faults immediately instead of waiting for window end.
      if (&stall_q[i]) begin
        state_d[i] = StFault;
        run_d[i]   = '0;
      end
`endif
      if (!ChEnable[i]) begin
        edgecnt_d[i] = '0;
        fan_cnt_d[i*CNT_W +: CNT_W] = '0;
        low_d[i]     = 1'b0;
        high_d[i]    = 1'b0;
        state_d[i]   = StOk;
        run_d[i]     = '0;
`ifdef FAN_TACH_STALL_EN
        stall_d[i]   = '0;
`endif
      end
      fault_d[i] = (state_d[i] == StFault);
    end
  end

  always_ff @(posedge CLKi or negedge ResetNi) begin
    if (!ResetNi) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      sync3_q    <= '0;
      win_q      <= '0;
      fan_cnt_q  <= '0;
      low_q      <= '0;
      high_q     <= '0;
      fault_q    <= '0;
      win_done_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        edgecnt_q[i] <= '0;
        state_q[i]   <= StOk;
        run_q[i]     <= '0;
`ifdef FAN_TACH_STALL_EN
        stall_q[i]   <= '0;
`endif
      end
    end else begin
      sync1_q    <= Fan_In;
      sync2_q    <= sync1_q;
      sync3_q    <= sync2_q;
      win_q      <= win_d;
      fan_cnt_q  <= fan_cnt_d;
      low_q      <= low_d;
      high_q     <= high_d;
      fault_q    <= fault_d;
      win_done_q <= tc;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        edgecnt_q[i] <= edgecnt_d[i];
        state_q[i]   <= state_d[i];
        run_q[i]     <= run_d[i];
`ifdef FAN_TACH_STALL_EN
        stall_q[i]   <= stall_d[i];
`endif
      end
    end
  end

  assign FanCnt   = fan_cnt_q;
  assign TachLow  = low_q;
  assign TachHigh = high_q;
  assign FanFault = fault_q;
  assign WinDone  = win_done_q;

endmodule

// File: tb/tb_fan_tach_monitor.sv
// Scoreboard bench for fan_tach_monitor: 256-cycle windows, directed tach patterns per window.
module tb_fan_tach_monitor;
  localparam int unsigned NumCh   = 2;
  localparam int unsigned CntW    = 12;
  localparam int unsigned WinLog2 = 8;
  localparam int unsigned FltCnt  = 3;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NumCh-1:0]      fan_in = '0;
  logic [NumCh-1:0]      ch_en = '1;
  logic [NumCh*CntW-1:0] fan_cnt;
  logic [NumCh-1:0]      tach_low, tach_high, fan_fault;
  logic                  win_done;

  fan_tach_monitor #(
    .NUM_CH  (NumCh),
    .CNT_W   (CntW),
    .WIN_LOG2(WinLog2),
    .FLT_CNT (FltCnt)
  ) u_dut (
    .CLKi    (clk),
    .ResetNi (rst_n),
    .Fan_In  (fan_in),
    .ChEnable(ch_en),
    .FanCnt  (fan_cnt),
    .TachLow (tach_low),
    .TachHigh(tach_high),
    .FanFault(fan_fault),
    .WinDone (win_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    logic [11:0] c0;
    logic [11:0] c1;
    logic [1:0]  chk;
    logic [1:0]  low;
    logic [1:0]  high;
    logic [1:0]  flt;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  int unsigned cyc = 0;
  int          phase = 0;
  int          checks = 0;
  int          failures = 0;

  // Cycles since reset release; matches the DUT window counter.
  always @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s at cyc %0d: got %0h expected %0h", name, cyc, act, req);
    end
  endtask

  task automatic push(input int unsigned c, input logic [11:0] c0, input logic [11:0] c1,
                      input logic [1:0] chk, input logic [1:0] low, input logic [1:0] flt);
    exp_t x;
    x.cyc = c; x.c0 = c0; x.c1 = c1; x.chk = chk; x.low = low; x.high = 2'b00; x.flt = flt;
    exp_q.push_back(x);
  endtask

  // Toggle period per channel and window; 0 holds the input.
  function automatic int unsigned period_for(input int ch, input int ph, input int unsigned n);
    int unsigned w;
    w = n / 256 + 1;
    if (ph == 1) return 4;
    if (ch == 0) begin
      if (w == 7 || w == 9) return 0;
      if (w == 11 || w == 12) return 1;
      return 4;
    end
    if (w <= 3 || w >= 13) return 0;
    return 4;
  endfunction

  always @(negedge clk) begin
    if (rst_n && cyc > 0) begin
      for (int ch = 0; ch < 2; ch++) begin
        int unsigned p;
        logic        tog;
        p   = period_for(ch, phase, cyc);
        tog = (p != 0) && (cyc % p == 0);
        if (phase == 0 && ch == 1 && (cyc == 3325 || cyc == 3326)) tog = 1'b1;
        if (tog) fan_in[ch] = ~fan_in[ch];
      end
    end
  end

  always @(negedge clk) begin
    if (win_done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL windone_unexpected at cyc %0d: got 1 expected 0", cyc);
      end else begin
        e = exp_q.pop_front();
        check("win_cycle", cyc, e.cyc);
        if (e.chk[0]) check("fan_cnt0", {20'd0, fan_cnt[11:0]}, {20'd0, e.c0});
        if (e.chk[1]) check("fan_cnt1", {20'd0, fan_cnt[23:12]}, {20'd0, e.c1});
        check("tach_low", {30'd0, tach_low}, {30'd0, e.low});
        check("tach_high", {30'd0, tach_high}, {30'd0, e.high});
        check("fan_fault", {30'd0, fan_fault}, {30'd0, e.flt});
      end
    end
  end

  task automatic wait_cyc(input int unsigned n);
    int guard;
    guard = 0;
    while (cyc != n) begin
      @(negedge clk);
      guard++;
      if (guard > 20000) begin
        $display("FAIL wait_cyc timeout: got cyc %0d expected %0d", cyc, n);
        $fatal(1, "bench stuck");
      end
    end
  endtask

  initial begin
    push(256 * 1,  12'd31,  12'd0,  2'b11, 2'b10, 2'b00);
    push(256 * 2,  12'd32,  12'd0,  2'b11, 2'b10, 2'b00);
    push(256 * 3,  12'd32,  12'd0,  2'b11, 2'b10, 2'b10);
    push(256 * 4,  12'd32,  12'd32, 2'b11, 2'b00, 2'b10);
    push(256 * 5,  12'd32,  12'd32, 2'b11, 2'b00, 2'b10);
    push(256 * 6,  12'd32,  12'd32, 2'b11, 2'b00, 2'b00);
    push(256 * 7,  12'd0,   12'd32, 2'b11, 2'b01, 2'b00);
    push(256 * 8,  12'd32,  12'd32, 2'b11, 2'b00, 2'b00);
    push(256 * 9,  12'd0,   12'd32, 2'b11, 2'b01, 2'b00);
    push(256 * 10, 12'd32,  12'd32, 2'b11, 2'b00, 2'b00);
    push(256 * 11, 12'h07E, 12'd32, 2'b11, 2'b00, 2'b00);
    push(256 * 12, 12'h080, 12'd32, 2'b11, 2'b00, 2'b00);
    push(256 * 13, 12'd33,  12'd0,  2'b11, 2'b10, 2'b00);
    push(256 * 14, 12'd32,  12'd1,  2'b11, 2'b10, 2'b00);
    push(256 * 15, 12'd32,  12'd0,  2'b11, 2'b10, 2'b10);

    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Stopped ch1 must not fault before its third window closes.
    wait_cyc(760);
    check("early_fault", {30'd0, fan_fault}, 32'd0);

    wait_cyc(3940);
    rst_n = 1'b0;
    #1;
    check("rst_fan_cnt", {8'd0, fan_cnt}, 32'd0);
    check("rst_tach_low", {30'd0, tach_low}, 32'd0);
    check("rst_tach_high", {30'd0, tach_high}, 32'd0);
    check("rst_fan_fault", {30'd0, fan_fault}, 32'd0);
    check("rst_win_done", {31'd0, win_done}, 32'd0);
    check("pre_rst_queue", exp_q.size(), 32'd0);
    phase = 1;
    push(256 * 1, 12'd0,  12'd0,  2'b00, 2'b00, 2'b00);
    push(256 * 2, 12'd32, 12'd32, 2'b11, 2'b00, 2'b00);
    push(256 * 3, 12'd0,  12'd32, 2'b11, 2'b00, 2'b00);
    push(256 * 4, 12'd16, 12'd32, 2'b11, 2'b01, 2'b00);
    push(256 * 5, 12'd32, 12'd32, 2'b11, 2'b00, 2'b00);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    wait_cyc(612);
    ch_en = 2'b10;
    @(posedge clk);
    #1;
    check("dis_fan_cnt0", {20'd0, fan_cnt[11:0]}, 32'd0);
    check("dis_fan_cnt1", {20'd0, fan_cnt[23:12]}, 32'd32);
    check("dis_tach_low0", {31'd0, tach_low[0]}, 32'd0);
    check("dis_tach_high0", {31'd0, tach_high[0]}, 32'd0);
    check("dis_fan_fault0", {31'd0, fan_fault[0]}, 32'd0);

    wait_cyc(896);
    ch_en = 2'b11;

    wait_cyc(1290);
    check("final_queue", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fan_tach_monitor.md
# fan_tach_monitor

Multi-channel fan tachometer monitor: the parametrised successor to the single-channel PSU fan frequency detector. It sits in the Control hierarchy next to the power/LED logic and runs on the 32768 Hz slow clock. For each channel it measures the tach pulse rate over a fixed window and flags low or high speed. It also runs a per-channel fault state machine with hysteresis, so the LED and status logic sees filtered faults instead of raw window results.

## Interface
Parameters:
- NUM_CH, 2, number of fan channels.
- CNT_W, 12, width of each per-channel result and of the edge counter.
- WIN_LOG2, 15, measurement window length = 2^WIN_LOG2 CLKi cycles (1 s at 32768 Hz).
- MIN_TACH, 12'h014, low threshold. FanCnt <= MIN_TACH means low.
- MAX_TACH, 12'h0E0, high threshold. FanCnt > MAX_TACH means high.
- FLT_CNT, 3, consecutive bad windows to enter FAULT; also consecutive good windows to leave it. Range 1..15.

Ports:
- CLKi  in  1  slow clock, 32768 Hz.
- ResetNi  in  1  asynchronous, active-low reset.
- Fan_In  in  NUM_CH  raw tach inputs, asynchronous to CLKi.
- ChEnable  in  NUM_CH  per-channel enable, quasi-static.
- FanCnt  out  NUM_CH*CNT_W  last-window pulse count per channel; channel i occupies bits [i*CNT_W +: CNT_W].
- TachLow  out  NUM_CH  last window was at or below MIN_TACH.
- TachHigh  out  NUM_CH  last window was above MAX_TACH.
- FanFault  out  NUM_CH  filtered fault; high in state FAULT.
- WinDone  out  1  one-cycle pulse when results update.

## Operation
- Input path: each Fan_In passes through a 2-FF synchronizer, then a third register for edge detection. Both rising and falling edges count.
- Window timer: a shared WIN_LOG2-bit free-running counter. Terminal count (TC) is the all-ones value; the counter wraps to 0 after it.
- Edge counter: one per channel, CNT_W+1 bits, and it saturates at all-ones.
- At TC:
  - FanCnt <= edgecnt >> 1 (pulses = edges/2), truncated to CNT_W bits.
  - The edge counter reloads to 1 if an edge occurs in the TC cycle, otherwise to 0. No edge is lost across the window boundary.
- Flags at TC, registered together with FanCnt:
  - TachLow <= (new FanCnt <= MIN_TACH).
  - TachHigh <= (new FanCnt > MAX_TACH).
  - bad = TachLow | TachHigh.
- Fault FSM per channel, evaluated only at TC. It uses a 4-bit run counter `run`.
  - OK:
    - bad: run <= 1 and go to SUSPECT; if FLT_CNT == 1, go directly to FAULT.
    - good: stay in OK.
  - SUSPECT:
    - bad: run+1; when run+1 == FLT_CNT, go to FAULT and clear run.
    - good: go to OK and clear run.
  - FAULT:
    - good: run+1; when run+1 == FLT_CNT, go to OK.
    - bad: clear run.
- FanFault = (state == FAULT), registered.
- Disabled channel (ChEnable=0):
  - Edge counter, FanCnt, flags, run and FanFault are held at 0; state is OK.
  - On enable, the channel starts counting at once. Its first TC result is a partial window, and the FSM still evaluates it.
- Reset: every output, counter, synchronizer and state register goes to 0 / OK. WinDone is 0.
- Reset mid-window discards the partial count. The window restarts from 0 when ResetNi deasserts.

## Timing
- Fan_In edge to edge-counter increment: 3 CLKi cycles.
- FanCnt, TachLow, TachHigh, FanFault and WinDone all change in the cycle after the TC cycle. WinDone is high for exactly that one cycle.
- First update after reset: 2^WIN_LOG2 cycles after ResetNi deasserts.
- Max countable rate: one edge per cycle. Pulses above 2^CNT_W per window saturate FanCnt at all-ones and set TachHigh.
- Outputs are stable between WinDone pulses, except under FAN_TACH_STALL_EN.

## Configuration
- Macro: FAN_TACH_STALL_EN.
- Defined: adds a per-channel stall timer of WIN_LOG2-2 bits.
  - The timer clears on any synchronized edge and saturates at all-ones.
  - On reaching all-ones, FanFault asserts the next cycle and the FSM is forced to FAULT with run=0. This does not wait for TC.
  - Recovery follows the normal FSM rules.
  - The timer is held at 0 while the channel is disabled.
- Undefined: no stall timer. A stopped fan is detected only through TachLow at window end.

## Test plan
All scenarios use NUM_CH=2, WIN_LOG2=8 (256-cycle window), FLT_CNT=3 and default thresholds.
- Fan_In[0] toggles every 4 cycles (64 edges/window) -> at each WinDone, FanCnt[0]=12'h020, TachLow=0, TachHigh=0, FanFault=0.
- Fan_In[1] held constant -> FanCnt[1]=0, TachLow[1]=1 each window; FanFault[1] rises 1 cycle after the 3rd TC. Restore toggling every 4 cycles -> FanFault[1] falls 1 cycle after the 3rd good TC.
- Alternate bad/good windows on ch0 -> FanFault[0] never asserts (SUSPECT returns to OK).
- Fan_In[0] toggles every cycle (256 edges) -> FanCnt[0]=12'h080, no flags. Edge injected exactly in a TC cycle -> counted in the next window (next FanCnt includes it).
- Pulse ResetNi low mid-window, and separately drop ChEnable[0] mid-window -> all ch0 outputs read 0 within 1 cycle; the first post-reset WinDone comes exactly 256 cycles after deassertion.
- With FAN_TACH_STALL_EN: stop Fan_In[0] mid-window -> FanFault[0] asserts 64 cycles after the last edge, before TC. Without the macro, it asserts only at TC.
